// File: rtl/pe_pkg.sv
// Shared definitions for the PE array: sequencer state encoding and PE control bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_pkg;

    // Sequencer state encoding (binary)
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MAC      = 3'd1;
    localparam logic [2:0] ST_ADD_PSUM = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_OUT      = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_MAC      = ST_MAC,
        S_ADD_PSUM = ST_ADD_PSUM,
        S_DRAIN    = ST_DRAIN,
        S_OUT      = ST_OUT,
        S_DONE     = ST_DONE
    } seq_state_t;

    // Bit positions inside pe_control, decoded by the PE
    localparam int ACC_CLEAR = 2;
    localparam int SEL_PSUM  = 1;
    localparam int MAC       = 0;

    // Control word for the cycle that folds the bottom-PE psum into the accumulator
    localparam logic [2:0] PE_CTRL_ADD_PSUM = 3'b010;

endpackage

// File: rtl/pe_sequencer_updown_counter.sv
// Loadable up/down counter with terminal-count compare.
// Latency: count updates one cycle after load/enable; o_tc is combinational from the count.
// Backpressure: none; holds its value whenever i_en is low.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_load_val (load wins over enable),
//        i_en, i_up (1 = increment, 0 = decrement), i_term (tc compare value),
//        o_cnt (current count), o_tc (o_cnt == i_term).
module updown_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= i_up ? (r_cnt + W'(1)) : (r_cnt - W'(1));
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/pe_sequencer.sv
// Sequences one PE through MAC beats, optional bottom-psum add, pipeline drain and psum output.
// Latency: S beats + (1 psum add) + PIPE_LAT drain + 1 output cycle per window, then 1 done cycle.
// Backpressure: stalls in MAC on !op_valid, in ADD_PSUM on !psum_in_valid, in OUT on !psum_out_ready.
// Ports: clk/rst (sync active-high); start + cfg_* (latched in IDLE); op_valid/op_ready operand beats;
//        psum_in_* bottom psum; psum_out_* result; pe_*_enable + pe_control to the PE; busy, done.
module pe_sequencer
    import pe_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_filter_len,
    input  logic [CNT_W-1:0] cfg_num_windows,
    input  logic             cfg_accum_psum,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             psum_in_valid,
    output logic             psum_in_ready,
    output logic             psum_out_valid,
    input  logic             psum_out_ready,
    output logic             pe_ifmap_enable,
    output logic             pe_filter_enable,
    output logic             pe_psum_enable,
    output logic [2:0]       pe_control,
    output logic             busy,
    output logic             done
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [CNT_W-1:0] r_filter_len;
    logic [CNT_W-1:0] r_num_windows;
    logic             r_accum;

    logic             w_start_acc;
    logic             w_mac_hs;
    logic             w_out_hs;
    logic             w_drain_entry;
    logic [CNT_W-1:0] w_beat_cnt;
    logic [CNT_W-1:0] w_win_cnt;
    logic [CNT_W-1:0] w_drain_cnt;
    logic             w_beat_tc;
    logic             w_win_tc;
    logic             w_drain_tc;
    logic             w_unused_cnt;

    assign w_start_acc   = (r_state == S_IDLE) && start;
    assign w_mac_hs      = (r_state == S_MAC) && op_valid;
    assign w_out_hs      = (r_state == S_OUT) && psum_out_ready;
    assign w_drain_entry = (r_state != S_DRAIN) && (w_next == S_DRAIN);

    // Only the terminal flags of the window and drain counters drive decisions
    assign w_unused_cnt = ^{w_win_cnt, w_drain_cnt};

    // Config is captured once per pass; zero lengths are promoted to one here
    // so the counters never need to handle an empty range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filter_len  <= '0;
            r_num_windows <= '0;
            r_accum       <= 1'b0;
        end else if (w_start_acc) begin
            r_filter_len  <= (cfg_filter_len  == '0) ? CNT_W'(1) : cfg_filter_len;
            r_num_windows <= (cfg_num_windows == '0) ? CNT_W'(1) : cfg_num_windows;
            r_accum       <= cfg_accum_psum;
        end
    end

    // Beat counter: counts accepted MAC beats in the current window
    updown_counter #(.W(CNT_W)) u_beat_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_start_acc || w_out_hs),
        .i_load_val ('0),
        .i_en       (w_mac_hs),
        .i_up       (1'b1),
        .i_term     (r_filter_len - CNT_W'(1)),
        .o_cnt      (w_beat_cnt),
        .o_tc       (w_beat_tc)
    );

    // Window counter: counts psums handed off in this pass
    updown_counter #(.W(CNT_W)) u_win_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_start_acc),
        .i_load_val ('0),
        .i_en       (w_out_hs),
        .i_up       (1'b1),
        .i_term     (r_num_windows - CNT_W'(1)),
        .o_cnt      (w_win_cnt),
        .o_tc       (w_win_tc)
    );

    // Drain counter: loaded on entry and counted down to zero, so DRAIN lasts PIPE_LAT cycles
    updown_counter #(.W(CNT_W)) u_drain_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_drain_entry),
        .i_load_val (CNT_W'(PIPE_LAT - 1)),
        .i_en       (r_state == S_DRAIN),
        .i_up       (1'b0),
        .i_term     ('0),
        .o_cnt      (w_drain_cnt),
        .o_tc       (w_drain_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Valid/ready outputs depend on state only; the PE enables follow the
    // accepted handshake so a stalled beat never touches the PE.
    always_comb begin
        w_next           = r_state;
        op_ready         = 1'b0;
        psum_in_ready    = 1'b0;
        psum_out_valid   = 1'b0;
        pe_ifmap_enable  = 1'b0;
        pe_filter_enable = 1'b0;
        pe_psum_enable   = 1'b0;
        pe_control       = 3'b000;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_MAC;
            end
            S_MAC: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    pe_ifmap_enable       = 1'b1;
                    pe_filter_enable      = 1'b1;
                    pe_psum_enable        = 1'b1;
                    pe_control[MAC]       = 1'b1;
                    pe_control[ACC_CLEAR] = (w_beat_cnt == '0);
                    if (w_beat_tc) w_next = r_accum ? S_ADD_PSUM : S_DRAIN;
                end
            end
            S_ADD_PSUM: begin
                psum_in_ready = 1'b1;
                if (psum_in_valid) begin
                    pe_psum_enable = 1'b1;
                    pe_control     = PE_CTRL_ADD_PSUM;
                    w_next         = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_tc) w_next = S_OUT;
            end
            S_OUT: begin
                psum_out_valid = 1'b1;
                if (psum_out_ready) w_next = w_win_tc ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: directed passes checked every cycle against a behavioural model.
// Latency: n/a.
// Backpressure: stimulus exercises operand, bottom-psum and output stalls.
module tb_pe_sequencer;

    localparam int CNT_W    = 8;
    localparam int PIPE_LAT = 2;

    localparam int P_IDLE  = 0;
    localparam int P_MAC   = 1;
    localparam int P_ADD   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_OUT   = 4;
    localparam int P_DONE  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_filter_len;
    logic [CNT_W-1:0] cfg_num_windows;
    logic             cfg_accum_psum;
    logic             op_valid;
    logic             op_ready;
    logic             psum_in_valid;
    logic             psum_in_ready;
    logic             psum_out_valid;
    logic             psum_out_ready;
    logic             pe_ifmap_enable;
    logic             pe_filter_enable;
    logic             pe_psum_enable;
    logic [2:0]       pe_control;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    pe_sequencer #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_filter_len   (cfg_filter_len),
        .cfg_num_windows  (cfg_num_windows),
        .cfg_accum_psum   (cfg_accum_psum),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .psum_in_valid    (psum_in_valid),
        .psum_in_ready    (psum_in_ready),
        .psum_out_valid   (psum_out_valid),
        .psum_out_ready   (psum_out_ready),
        .pe_ifmap_enable  (pe_ifmap_enable),
        .pe_filter_enable (pe_filter_enable),
        .pe_psum_enable   (pe_psum_enable),
        .pe_control       (pe_control),
        .busy             (busy),
        .done             (done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: phase plus beats/windows completed and drain cycles left
    int m_ph = P_IDLE;
    int m_S = 0, m_W = 0, m_acc = 0, m_beats = 0, m_wins = 0, m_drain = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = P_IDLE; m_S = 0; m_W = 0; m_acc = 0; m_beats = 0; m_wins = 0; m_drain = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (start) begin
                    m_S     = (cfg_filter_len  == 0) ? 1 : int'(cfg_filter_len);
                    m_W     = (cfg_num_windows == 0) ? 1 : int'(cfg_num_windows);
                    m_acc   = int'(cfg_accum_psum);
                    m_beats = 0;
                    m_wins  = 0;
                    m_ph    = P_MAC;
                end
                P_MAC: if (op_valid) begin
                    m_beats++;
                    if (m_beats == m_S) begin
                        if (m_acc != 0) m_ph = P_ADD;
                        else begin m_ph = P_DRAIN; m_drain = PIPE_LAT; end
                    end
                end
                P_ADD: if (psum_in_valid) begin m_ph = P_DRAIN; m_drain = PIPE_LAT; end
                P_DRAIN: begin
                    m_drain--;
                    if (m_drain == 0) m_ph = P_OUT;
                end
                P_OUT: if (psum_out_ready) begin
                    m_wins++;
                    m_beats = 0;
                    m_ph = (m_wins == m_W) ? P_DONE : P_MAC;
                end
                P_DONE: m_ph = P_IDLE;
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // {busy, done, op_ready, psum_in_ready, psum_out_valid, ifmap_en, filter_en, psum_en, control}
    function automatic logic [10:0] model_out();
        logic       mh, ah;
        logic [2:0] ctl;
        mh  = (m_ph == P_MAC) && op_valid;
        ah  = (m_ph == P_ADD) && psum_in_valid;
        ctl = mh ? {(m_beats == 0), 1'b0, 1'b1} : (ah ? 3'b010 : 3'b000);
        return {m_ph != P_IDLE, m_ph == P_DONE, m_ph == P_MAC, m_ph == P_ADD, m_ph == P_OUT,
                mh, mh, mh | ah, ctl};
    endfunction

    logic [10:0] dut_vec;
    assign dut_vec = {busy, done, op_ready, psum_in_ready, psum_out_valid,
                      pe_ifmap_enable, pe_filter_enable, pe_psum_enable, pe_control};

    // Event tallies, sampled mid-cycle from the DUT
    // 0 mac_en, 1 acc_clear, 2 sel_psum, 3 done, 4 out_hs, 5 out_valid, 6 add_wait, 7 busy, 8 op_ready
    int st[9];
    int base[9];

    always @(negedge clk) begin
        logic [10:0] exp_v;
        if (chk_en) begin
            exp_v = model_out();
            n_cmp++;
            if (dut_vec !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t dut=%b model=%b", $time, dut_vec, exp_v);
            end
            st[0] += int'(pe_ifmap_enable);
            st[1] += int'(pe_control[2]);
            st[2] += int'(pe_control == 3'b010);
            st[3] += int'(done);
            st[4] += int'(psum_out_valid & psum_out_ready);
            st[5] += int'(psum_out_valid);
            st[6] += int'(psum_in_ready & ~psum_in_valid);
            st[7] += int'(busy);
            st[8] += int'(op_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 9; i++) base[i] = st[i];
    endtask

    function automatic int dlt(input int i);
        return st[i] - base[i];
    endfunction

    task automatic start_pass(input int s, input int w, input int acc);
        cfg_filter_len  = CNT_W'(s);
        cfg_num_windows = CNT_W'(w);
        cfg_accum_psum  = (acc != 0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!done && k < max_cyc) begin
            tick();
            k++;
        end
        chk(name, int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pat[5] = '{1, 0, 0, 1, 1};
        for (int i = 0; i < 9; i++) begin st[i] = 0; base[i] = 0; end
        rst = 1'b1; start = 1'b0; cfg_filter_len = '0; cfg_num_windows = '0; cfg_accum_psum = 1'b0;
        op_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_op_ready", int'(op_ready), 0);
        chk("rst_out_valid", int'(psum_out_valid), 0);
        chk("rst_control", int'(pe_control), 0);

        // Basic pass: S=3, one window, no psum add
        op_valid = 1'b1; psum_out_ready = 1'b1;
        snap();
        start_pass(3, 1, 0);
        wait_done("t1_done_seen", 50);
        tick();
        op_valid = 1'b0;
        chk("t1_mac_beats", dlt(0), 3);
        chk("t1_acc_clear", dlt(1), 1);
        chk("t1_done_pulses", dlt(3), 1);
        chk("t1_out_hs", dlt(4), 1);
        chk("t1_busy_cycles", dlt(7), 7);

        // Two windows with psum add, bottom psum delayed 5 cycles each time
        op_valid = 1'b1; psum_out_ready = 1'b1; w = 0;
        snap();
        start_pass(3, 2, 1);
        for (int k = 0; k < 200 && !done; k++) begin
            if (psum_in_ready) begin
                if (w < 5) begin w++; psum_in_valid = 1'b0; end
                else begin psum_in_valid = 1'b1; w = 0; end
            end else begin
                psum_in_valid = 1'b0;
            end
            tick();
        end
        chk("t2_done_seen", int'(done), 1);
        psum_in_valid = 1'b0;
        tick();
        op_valid = 1'b0;
        chk("t2_mac_beats", dlt(0), 6);
        chk("t2_acc_clear", dlt(1), 2);
        chk("t2_sel_psum", dlt(2), 2);
        chk("t2_add_wait", dlt(6), 10);
        chk("t2_out_hs", dlt(4), 2);
        chk("t2_done_pulses", dlt(3), 1);
        chk("t2_busy_cycles", dlt(7), 25);
        chk("t2_model_windows", m_wins, 2);

        // Operand gaps: valid pattern 1,0,0,1,1 with S=3
        psum_out_ready = 1'b1;
        snap();
        start_pass(3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            op_valid = (pat[i] != 0);
            tick();
        end
        op_valid = 1'b0;
        wait_done("t3_done_seen", 50);
        tick();
        chk("t3_mac_beats", dlt(0), 3);
        chk("t3_ready_cycles", dlt(8), 5);
        chk("t3_acc_clear", dlt(1), 1);

        // Output backpressure: ready low for 10 cycles of valid
        op_valid = 1'b1; psum_out_ready = 1'b0;
        snap();
        start_pass(1, 1, 0);
        for (int k = 0; k < 20 && !psum_out_valid; k++) tick();
        chk("t4_out_valid_seen", int'(psum_out_valid), 1);
        op_valid = 1'b0;
        repeat (10) tick();
        chk("t4_valid_held", int'(psum_out_valid), 1);
        psum_out_ready = 1'b1;
        wait_done("t4_done_seen", 20);
        tick();
        chk("t4_valid_cycles", dlt(5), 11);
        chk("t4_out_hs", dlt(4), 1);
        chk("t4_mac_beats", dlt(0), 1);

        // Reset mid-pass during beat 2 of S=4, then a clean S=1 pass
        op_valid = 1'b1; psum_out_ready = 1'b1;
        snap();
        start_pass(4, 1, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy_after_rst", int'(busy), 0);
        chk("t5_ready_after_rst", int'(op_ready), 0);
        chk("t5_ifmap_after_rst", int'(pe_ifmap_enable), 0);
        chk("t5_ctrl_after_rst", int'(pe_control), 0);
        repeat (4) tick();
        chk("t5_no_done_aborted", dlt(3), 0);
        chk("t5_aborted_beats", dlt(0), 3);
        snap();
        start_pass(1, 1, 0);
        wait_done("t5_done_seen", 20);
        tick();
        chk("t5_fresh_beats", dlt(0), 1);
        chk("t5_fresh_done", dlt(3), 1);

        // Zero config treated as 1/1; start held (with new cfg) while busy
        op_valid = 1'b1; psum_out_ready = 1'b1;
        snap();
        cfg_filter_len = '0; cfg_num_windows = '0; cfg_accum_psum = 1'b0;
        start = 1'b1;
        tick();
        cfg_filter_len = 8'd5; cfg_num_windows = 8'd3;
        wait_done("t6_done_seen", 30);
        start = 1'b0;
        repeat (4) tick();
        op_valid = 1'b0;
        chk("t6_done_pulses", dlt(3), 1);
        chk("t6_mac_beats", dlt(0), 1);
        chk("t6_busy_cycles", dlt(7), 5);
        chk("t6_idle_after", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
